// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: bus layouts, load opcodes,
// exception indices and the response-tracking FSM encoding.
package mem_stage_pkg;

  localparam int EXE_BUS_W = 191;
  localparam int WB_BUS_W  = 220;
  localparam int WR_BUS_W  = 39;

  localparam int EX_SYS  = 0;
  localparam int EX_ADEF = 1;
  localparam int EX_ALE  = 2;
  localparam int EX_BRK  = 3;
  localparam int EX_INE  = 4;
  localparam int EX_INT  = 5;

  localparam logic [9:0] OP_LD_B  = 10'h0a0;
  localparam logic [9:0] OP_LD_H  = 10'h0a1;
  localparam logic [9:0] OP_LD_W  = 10'h0a2;
  localparam logic [9:0] OP_LD_BU = 10'h0a8;
  localparam logic [9:0] OP_LD_HU = 10'h0a9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } mem_state_e;

  typedef struct packed {
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        inst_ertn;
    logic [5:0]  ex_type;
    logic [31:0] exe_result;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ls_cancel;
    logic        mem_we;
  } exe_bus_t;

  // True when EXE actually handed a request to the data SRAM for this instruction.
  function automatic logic is_mem_acc(input exe_bus_t b);
    return (b.res_from_mem | b.mem_we) & ~b.ls_cancel & ~(|b.ex_type);
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load-data alignment and sign/zero extension for ld.b/bu/h/hu/w.
module mem_load_ext
  import mem_stage_pkg::*;
(
  input  logic [9:0]  op,
  input  logic [1:0]  off,
  input  logic [31:0] rdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  always_comb begin
    byte_s    = rdata[{off, 3'b000} +: 8];
    half_s    = off[1] ? rdata[31:16] : rdata[15:0];
    load_data = rdata;
    case (op)
      OP_LD_B:  load_data = {{24{byte_s[7]}}, byte_s};
      OP_LD_BU: load_data = {24'h000000, byte_s};
      OP_LD_H:  load_data = {{16{half_s[15]}}, half_s};
      OP_LD_HU: load_data = {16'h0000, half_s};
      OP_LD_W:  load_data = rdata;
      default:  load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the LA32R pipeline: holds the EXE result, tracks the data-SRAM
// response, extends load data and forwards to WB.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  output logic                 MEM_allow_in,
  input  logic                 EXE_to_MEM_valid,
  input  logic [EXE_BUS_W-1:0] EXE_to_MEM_bus,
  output logic                 MEM_to_WB_valid,
  input  logic                 WB_allow_in,
  output logic [WB_BUS_W-1:0]  MEM_to_WB_bus,
  input  logic                 data_sram_data_ok,
  input  logic [31:0]          data_sram_rdata,
  output logic [WR_BUS_W-1:0]  MEM_wr_bus,
  output logic                 MEM_ex,
  output logic                 MEM_ertn,
  output logic                 ldst_cancel,
  input  logic                 wb_ex,
  input  logic                 ertn_flush
);

  exe_bus_t   bus_q, bus_d, in_bus_s;
  logic       valid_q, valid_d;
  mem_state_e state_q, state_d;
  logic [31:0] buf_q, buf_d;

  logic        flush_s, mem_acc_s, ready_go_s, allow_in_s, latch_s, new_acc_s;
  logic [31:0] rd_s, load_data_s, final_s;

  assign in_bus_s  = EXE_to_MEM_bus;
  assign flush_s   = wb_ex | ertn_flush;
  assign mem_acc_s = is_mem_acc(bus_q);

  always_comb begin
    ready_go_s = ~mem_acc_s | ((state_q == S_WAIT) & data_sram_data_ok) | (state_q == S_HOLD);
    allow_in_s = (state_q != S_DROP) & (~valid_q | (ready_go_s & WB_allow_in));
    latch_s    = EXE_to_MEM_valid & allow_in_s;
    new_acc_s  = latch_s & is_mem_acc(in_bus_s) & ~flush_s;
  end

  always_comb begin
    valid_d = valid_q;
    bus_d   = bus_q;
    if (flush_s) begin
      valid_d = 1'b0;
    end else if (allow_in_s) begin
      valid_d = EXE_to_MEM_valid;
    end else begin
      valid_d = valid_q;
    end
    if (latch_s) begin
      bus_d = in_bus_s;
    end else begin
      bus_d = bus_q;
    end
  end

  // A flushed request still owes one response; S_DROP absorbs it before new issues.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    case (state_q)
      S_IDLE: begin
        if (new_acc_s) state_d = S_WAIT;
        else           state_d = S_IDLE;
      end
      S_WAIT: begin
        if (data_sram_data_ok) begin
          if (flush_s) begin
            state_d = S_IDLE;
          end else if (!WB_allow_in) begin
            state_d = S_HOLD;
            buf_d   = data_sram_rdata;
          end else if (new_acc_s) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_IDLE;
          end
        end else if (flush_s) begin
          state_d = S_DROP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_HOLD: begin
        if (flush_s)          state_d = S_IDLE;
        else if (WB_allow_in) state_d = new_acc_s ? S_WAIT : S_IDLE;
        else                  state_d = S_HOLD;
      end
      S_DROP: begin
        if (data_sram_data_ok) state_d = S_IDLE;
        else                   state_d = S_DROP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      bus_q   <= '0;
      state_q <= S_IDLE;
      buf_q   <= 32'h0000_0000;
    end else begin
      valid_q <= valid_d;
      bus_q   <= bus_d;
      state_q <= state_d;
      buf_q   <= buf_d;
    end
  end

  assign rd_s = (state_q == S_HOLD) ? buf_q : data_sram_rdata;

  mem_load_ext u_load_ext (
    .op        (bus_q.inst[31:22]),
    .off       (bus_q.exe_result[1:0]),
    .rdata     (rd_s),
    .load_data (load_data_s)
  );

  assign final_s = bus_q.res_from_mem ? load_data_s : bus_q.exe_result;

  assign MEM_allow_in    = allow_in_s;
  assign MEM_to_WB_valid = valid_q & ready_go_s & ~flush_s;
  assign MEM_to_WB_bus   = {bus_q.csr_we, bus_q.csr_num, bus_q.csr_wmask, bus_q.csr_wvalue,
                            bus_q.inst_ertn, bus_q.ex_type, bus_q.exe_result, final_s,
                            bus_q.gr_we, bus_q.dest, bus_q.pc, bus_q.inst};
  assign MEM_wr_bus      = {valid_q & bus_q.gr_we, valid_q & bus_q.res_from_mem & ~ready_go_s,
                            bus_q.dest, final_s};
  assign MEM_ex          = valid_q & (|bus_q.ex_type);
  assign MEM_ertn        = valid_q & bus_q.inst_ertn;
  assign ldst_cancel     = MEM_ex | MEM_ertn;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         resetn;
  logic         MEM_allow_in;
  logic         EXE_to_MEM_valid;
  logic [190:0] EXE_to_MEM_bus;
  logic         MEM_to_WB_valid;
  logic         WB_allow_in;
  logic [219:0] MEM_to_WB_bus;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic [38:0]  MEM_wr_bus;
  logic         MEM_ex, MEM_ertn, ldst_cancel;
  logic         wb_ex, ertn_flush;

  int n_checks = 0;
  int n_errors = 0;
  int xfer_cnt = 0;
  logic [219:0] last_bus = '0;

  localparam logic [9:0] LD_B  = 10'h0a0;
  localparam logic [9:0] LD_H  = 10'h0a1;
  localparam logic [9:0] LD_W  = 10'h0a2;
  localparam logic [9:0] ST_W  = 10'h0a6;
  localparam logic [9:0] LD_BU = 10'h0a8;

  mem_stage dut (
    .clk(clk), .resetn(resetn), .MEM_allow_in(MEM_allow_in),
    .EXE_to_MEM_valid(EXE_to_MEM_valid), .EXE_to_MEM_bus(EXE_to_MEM_bus),
    .MEM_to_WB_valid(MEM_to_WB_valid), .WB_allow_in(WB_allow_in),
    .MEM_to_WB_bus(MEM_to_WB_bus), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata), .MEM_wr_bus(MEM_wr_bus), .MEM_ex(MEM_ex),
    .MEM_ertn(MEM_ertn), .ldst_cancel(ldst_cancel), .wb_ex(wb_ex), .ertn_flush(ertn_flush)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [190:0] make_bus(input logic ertn, input logic [5:0] ext,
      input logic [31:0] res, input logic rfm, input logic gw, input logic [4:0] dst,
      input logic [31:0] pc, input logic [31:0] inst, input logic lsc, input logic mwe);
    return {1'b1, 14'h0010, 32'hFFFF_0000, 32'h1234_0000, ertn, ext, res, rfm, gw, dst, pc, inst, lsc, mwe};
  endfunction

  function automatic logic [219:0] make_wb(input logic ertn, input logic [5:0] ext,
      input logic [31:0] vaddr, input logic [31:0] fin, input logic gw, input logic [4:0] dst,
      input logic [31:0] pc, input logic [31:0] inst);
    return {1'b1, 14'h0010, 32'hFFFF_0000, 32'h1234_0000, ertn, ext, vaddr, fin, gw, dst, pc, inst};
  endfunction

  // Called on a negedge; counts the transfer (if any) at the coming posedge.
  task automatic step();
    #1;
    if (MEM_to_WB_valid && WB_allow_in) begin
      xfer_cnt = xfer_cnt + 1;
      last_bus = MEM_to_WB_bus;
    end
    @(negedge clk);
  endtask

  task automatic issue(input logic [190:0] b);
    EXE_to_MEM_valid = 1'b1;
    EXE_to_MEM_bus   = b;
    step();
    EXE_to_MEM_valid = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; EXE_to_MEM_valid = 1'b0; EXE_to_MEM_bus = '0; WB_allow_in = 1'b1;
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0; wb_ex = 1'b0; ertn_flush = 1'b0;
    #12;
    n_checks++; if (MEM_to_WB_valid !== 1'b0) begin n_errors++; $display("FAIL rst_valid: got %b want 0", MEM_to_WB_valid); end
    n_checks++; if (MEM_allow_in !== 1'b1) begin n_errors++; $display("FAIL rst_allow: got %b want 1", MEM_allow_in); end
    n_checks++; if (MEM_to_WB_bus !== 220'd0) begin n_errors++; $display("FAIL rst_wb_bus: got %h want 0", MEM_to_WB_bus); end
    n_checks++; if (MEM_wr_bus !== 39'd0) begin n_errors++; $display("FAIL rst_wr_bus: got %h want 0", MEM_wr_bus); end
    n_checks++; if ({MEM_ex, MEM_ertn, ldst_cancel} !== 3'b000) begin n_errors++; $display("FAIL rst_ex: got %b want 000", {MEM_ex, MEM_ertn, ldst_cancel}); end
    @(negedge clk); resetn = 1'b1;
    step();
  endtask

  task automatic test_ld_w();
    logic [31:0] inst;
    logic [219:0] exp;
    int c0;
    c0 = xfer_cnt;
    inst = {LD_W, 22'h012345};
    exp = make_wb(1'b0, 6'd0, 32'h1000, 32'hDEAD_BEEF, 1'b1, 5'd5, 32'h1C00_0010, inst);
    issue(make_bus(1'b0, 6'd0, 32'h1000, 1'b1, 1'b1, 5'd5, 32'h1C00_0010, inst, 1'b0, 1'b0));
    #1;
    n_checks++; if (MEM_to_WB_valid !== 1'b0) begin n_errors++; $display("FAIL ldw_wait_valid: got %b want 0", MEM_to_WB_valid); end
    n_checks++; if (MEM_allow_in !== 1'b0) begin n_errors++; $display("FAIL ldw_wait_allow: got %b want 0", MEM_allow_in); end
    n_checks++; if (MEM_wr_bus !== {1'b1, 1'b1, 5'd5, 32'h0}) begin n_errors++; $display("FAIL ldw_fwd_pending: got %h want %h", MEM_wr_bus, {1'b1, 1'b1, 5'd5, 32'h0}); end
    step();
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF;
    #1;
    n_checks++; if (MEM_to_WB_valid !== 1'b1) begin n_errors++; $display("FAIL ldw_valid: got %b want 1", MEM_to_WB_valid); end
    n_checks++; if (MEM_to_WB_bus !== exp) begin n_errors++; $display("FAIL ldw_wb_bus: got %h want %h", MEM_to_WB_bus, exp); end
    n_checks++; if (MEM_wr_bus !== {1'b1, 1'b0, 5'd5, 32'hDEAD_BEEF}) begin n_errors++; $display("FAIL ldw_fwd_done: got %h", MEM_wr_bus); end
    step();
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
    step(); step();
    n_checks++; if (xfer_cnt !== c0 + 1) begin n_errors++; $display("FAIL ldw_xfer_cnt: got %0d want %0d", xfer_cnt, c0 + 1); end
    n_checks++; if (last_bus !== exp) begin n_errors++; $display("FAIL ldw_last_bus: got %h want %h", last_bus, exp); end
  endtask

  task automatic test_load_ext();
    logic [9:0]  ops  [3] = '{LD_B, LD_BU, LD_H};
    logic [31:0] addr [3] = '{32'h1003, 32'h1003, 32'h1002};
    logic [31:0] expv [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF};
    logic [31:0] inst;
    logic [219:0] exp;
    for (int i = 0; i < 3; i++) begin
      inst = {ops[i], 22'h000421};
      exp = make_wb(1'b0, 6'd0, addr[i], expv[i], 1'b1, 5'd6, 32'h1C00_0040, inst);
      issue(make_bus(1'b0, 6'd0, addr[i], 1'b1, 1'b1, 5'd6, 32'h1C00_0040, inst, 1'b0, 1'b0));
      data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80FF_0000;
      #1;
      n_checks++; if (MEM_to_WB_bus !== exp) begin n_errors++; $display("FAIL ldext_%0d: got %h want %h", i, MEM_to_WB_bus[101:70], expv[i]); end
      step();
      data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
    end
  endtask

  task automatic test_hold();
    logic [31:0] inst;
    logic [219:0] exp;
    int c0;
    c0 = xfer_cnt;
    inst = {LD_W, 22'h00abcd};
    exp = make_wb(1'b0, 6'd0, 32'h1100, 32'h1234_5678, 1'b1, 5'd7, 32'h1C00_0020, inst);
    WB_allow_in = 1'b0;
    issue(make_bus(1'b0, 6'd0, 32'h1100, 1'b1, 1'b1, 5'd7, 32'h1C00_0020, inst, 1'b0, 1'b0));
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1234_5678;
    #1;
    n_checks++; if (MEM_allow_in !== 1'b0) begin n_errors++; $display("FAIL hold_allow_at_ok: got %b want 0", MEM_allow_in); end
    step();
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'hAAAA_AAAA;
    #1;
    n_checks++; if (MEM_to_WB_valid !== 1'b1) begin n_errors++; $display("FAIL hold_valid: got %b want 1", MEM_to_WB_valid); end
    n_checks++; if (MEM_to_WB_bus !== exp) begin n_errors++; $display("FAIL hold_bus_buffer: got %h want %h", MEM_to_WB_bus, exp); end
    n_checks++; if (MEM_wr_bus !== {1'b1, 1'b0, 5'd7, 32'h1234_5678}) begin n_errors++; $display("FAIL hold_fwd: got %h", MEM_wr_bus); end
    step(); step();
    WB_allow_in = 1'b1;
    step();
    n_checks++; if (last_bus !== exp) begin n_errors++; $display("FAIL hold_last_bus: got %h want %h", last_bus, exp); end
    step(); step();
    n_checks++; if (xfer_cnt !== c0 + 1) begin n_errors++; $display("FAIL hold_no_dup: got %0d want %0d", xfer_cnt, c0 + 1); end
    data_sram_rdata = 32'h0;
  endtask

  task automatic test_drop();
    logic [31:0] inst;
    logic [219:0] exp;
    int c0;
    c0 = xfer_cnt;
    inst = {LD_W, 22'h000111};
    issue(make_bus(1'b0, 6'd0, 32'h1200, 1'b1, 1'b1, 5'd9, 32'h1C00_0060, inst, 1'b0, 1'b0));
    wb_ex = 1'b1;
    #1;
    n_checks++; if (MEM_to_WB_valid !== 1'b0) begin n_errors++; $display("FAIL drop_flush_valid: got %b want 0", MEM_to_WB_valid); end
    step();
    wb_ex = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (MEM_allow_in !== 1'b0) begin n_errors++; $display("FAIL drop_allow_%0d: got %b want 0", i, MEM_allow_in); end
      step();
    end
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hBAD0_BAD0;
    #1;
    n_checks++; if ({MEM_allow_in, MEM_to_WB_valid} !== 2'b00) begin n_errors++; $display("FAIL drop_at_ok: got %b want 00", {MEM_allow_in, MEM_to_WB_valid}); end
    step();
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
    #1;
    n_checks++; if (MEM_allow_in !== 1'b1) begin n_errors++; $display("FAIL drop_allow_after: got %b want 1", MEM_allow_in); end
    n_checks++; if (xfer_cnt !== c0) begin n_errors++; $display("FAIL drop_no_stale: got %0d want %0d", xfer_cnt, c0); end
    inst = {LD_W, 22'h000222};
    exp = make_wb(1'b0, 6'd0, 32'h1204, 32'h0BAD_F00D, 1'b1, 5'd10, 32'h1C00_0064, inst);
    issue(make_bus(1'b0, 6'd0, 32'h1204, 1'b1, 1'b1, 5'd10, 32'h1C00_0064, inst, 1'b0, 1'b0));
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0BAD_F00D;
    step();
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
    n_checks++; if (xfer_cnt !== c0 + 1 || last_bus !== exp) begin n_errors++; $display("FAIL drop_next_load: got cnt %0d bus %h want cnt %0d bus %h", xfer_cnt, last_bus, c0 + 1, exp); end
  endtask

  task automatic test_ale();
    logic [31:0] inst;
    logic [219:0] exp;
    int c0;
    c0 = xfer_cnt;
    inst = {LD_W, 22'h000333};
    exp = make_wb(1'b0, 6'b000100, 32'h1001, 32'h0, 1'b1, 5'd3, 32'h1C00_0080, inst);
    issue(make_bus(1'b0, 6'b000100, 32'h1001, 1'b1, 1'b1, 5'd3, 32'h1C00_0080, inst, 1'b1, 1'b0));
    #1;
    n_checks++; if (MEM_to_WB_valid !== 1'b1) begin n_errors++; $display("FAIL ale_valid: got %b want 1", MEM_to_WB_valid); end
    n_checks++; if ({MEM_ex, MEM_ertn, ldst_cancel} !== 3'b101) begin n_errors++; $display("FAIL ale_ex: got %b want 101", {MEM_ex, MEM_ertn, ldst_cancel}); end
    n_checks++; if (MEM_to_WB_bus !== exp) begin n_errors++; $display("FAIL ale_bus: got %h want %h", MEM_to_WB_bus, exp); end
    n_checks++; if (MEM_allow_in !== 1'b1) begin n_errors++; $display("FAIL ale_allow: got %b want 1", MEM_allow_in); end
    step();
    #1;
    n_checks++; if (xfer_cnt !== c0 + 1) begin n_errors++; $display("FAIL ale_xfer: got %0d want %0d", xfer_cnt, c0 + 1); end
    n_checks++; if ({MEM_ex, ldst_cancel} !== 2'b00) begin n_errors++; $display("FAIL ale_ex_clear: got %b want 00", {MEM_ex, ldst_cancel}); end
  endtask

  task automatic test_ertn();
    issue(make_bus(1'b1, 6'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h1C00_0090, 32'h0648_3800, 1'b0, 1'b0));
    #1;
    n_checks++; if ({MEM_ex, MEM_ertn, ldst_cancel, MEM_to_WB_valid} !== 4'b0111) begin n_errors++; $display("FAIL ertn_flags: got %b want 0111", {MEM_ex, MEM_ertn, ldst_cancel, MEM_to_WB_valid}); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] st_inst, ld_inst;
    logic [219:0] exp_st, exp_ld;
    int c0;
    c0 = xfer_cnt;
    st_inst = {ST_W, 22'h000444};
    ld_inst = {LD_W, 22'h000555};
    exp_st = make_wb(1'b0, 6'd0, 32'h2000, 32'h2000, 1'b0, 5'd0, 32'h1C00_0100, st_inst);
    exp_ld = make_wb(1'b0, 6'd0, 32'h2004, 32'h55AA_1234, 1'b1, 5'd12, 32'h1C00_0104, ld_inst);
    EXE_to_MEM_valid = 1'b1;
    EXE_to_MEM_bus = make_bus(1'b0, 6'd0, 32'h2000, 1'b0, 1'b0, 5'd0, 32'h1C00_0100, st_inst, 1'b0, 1'b1);
    step();
    EXE_to_MEM_bus = make_bus(1'b0, 6'd0, 32'h2004, 1'b1, 1'b1, 5'd12, 32'h1C00_0104, ld_inst, 1'b0, 1'b0);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hFFFF_FFFF;
    #1;
    n_checks++; if (MEM_allow_in !== 1'b1) begin n_errors++; $display("FAIL b2b_allow: got %b want 1", MEM_allow_in); end
    n_checks++; if (MEM_to_WB_bus !== exp_st) begin n_errors++; $display("FAIL b2b_st_bus: got %h want %h", MEM_to_WB_bus, exp_st); end
    step();
    EXE_to_MEM_valid = 1'b0;
    data_sram_rdata = 32'h55AA_1234;
    #1;
    n_checks++; if (MEM_to_WB_valid !== 1'b1 || MEM_to_WB_bus !== exp_ld) begin n_errors++; $display("FAIL b2b_ld: got v=%b %h want v=1 %h", MEM_to_WB_valid, MEM_to_WB_bus, exp_ld); end
    step();
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
    #1;
    n_checks++; if (xfer_cnt !== c0 + 2) begin n_errors++; $display("FAIL b2b_xfers: got %0d want %0d", xfer_cnt, c0 + 2); end
    n_checks++; if ({MEM_allow_in, MEM_to_WB_valid} !== 2'b10) begin n_errors++; $display("FAIL b2b_idle: got %b want 10", {MEM_allow_in, MEM_to_WB_valid}); end
  endtask

  task automatic test_reset_mid();
    issue(make_bus(1'b0, 6'd0, 32'h3000, 1'b1, 1'b1, 5'd2, 32'h1C00_0200, {LD_W, 22'h0}, 1'b0, 1'b0));
    #2 resetn = 1'b0;
    #1;
    n_checks++; if ({MEM_allow_in, MEM_to_WB_valid} !== 2'b10) begin n_errors++; $display("FAIL midrst_flags: got %b want 10", {MEM_allow_in, MEM_to_WB_valid}); end
    n_checks++; if (MEM_wr_bus !== 39'd0) begin n_errors++; $display("FAIL midrst_wr_bus: got %h want 0", MEM_wr_bus); end
    @(negedge clk); resetn = 1'b1;
    step();
    #1;
    n_checks++; if (MEM_allow_in !== 1'b1) begin n_errors++; $display("FAIL midrst_allow_after: got %b want 1", MEM_allow_in); end
  endtask

  initial begin
    test_reset();
    test_ld_w();
    test_load_ext();
    test_hold();
    test_drop();
    test_ale();
    test_ertn();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
